// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the two requester ports (D = MEM stage, I = fetch), the pipeline
// status lines and the single-port memory bus seen by mem_port_arbiter.
//   slave  : arbiter view (requests and memory replies in; grants, data, status out)
//   master : environment view (pipeline + memory model), the mirror image
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // D port
  logic              d_ce;
  logic              d_wrn;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wrdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
  // I port
  logic              i_ce;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_done;
  // status
  logic              stall_o;
  logic              err_o;
  // memory bus
  logic              m_ce;
  logic              m_wrn;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wrdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ready;

  modport slave (
    input  d_ce, d_wrn, d_addr, d_wrdata,
    output d_rdata, d_done,
    input  i_ce, i_addr,
    output i_rdata, i_done,
    output stall_o, err_o,
    output m_ce, m_wrn, m_addr, m_wrdata,
    input  m_rdata, m_ready
  );

  modport master (
    output d_ce, d_wrn, d_addr, d_wrdata,
    input  d_rdata, d_done,
    output i_ce, i_addr,
    input  i_rdata, i_done,
    input  stall_o, err_o,
    input  m_ce, m_wrn, m_addr, m_wrdata,
    output m_rdata, m_ready
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port, variable-latency memory between the fetch port (I)
// and the MEM-stage port (D). Each access is a request/ready transaction that
// ends with a one-cycle done pulse to the grantee. D has fixed priority, but
// after STARVE_LIMIT consecutive D grants with I pending, I is forced. An
// access that sees no m_ready for TIMEOUT busy cycles is aborted with err_o.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : mem_port_arbiter_if.slave (D/I requester ports, stall_o, err_o,
//          memory bus m_*)
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 15
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  // to_cnt is 0 in the first busy cycle, so the TIMEOUT-th busy cycle has
  // to_cnt == TIMEOUT-1.
  localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

  logic [0:0]        state_q, state_d;
  logic              gnt_d_q, gnt_d_d;      // 1: current access belongs to D
  logic              m_ce_q, m_ce_d;
  logic              m_wrn_q, m_wrn_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wrdata_q, m_wrdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic              d_done_q, d_done_d;
  logic              i_done_q, i_done_d;
  logic              err_q, err_d;
  logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
  logic [3:0]        to_cnt_q, to_cnt_d;

  logic req_any;
  logic pick_d;

  assign req_any = bus.d_ce | bus.i_ce;
  assign pick_d  = bus.d_ce & ~(bus.i_ce & (starve_cnt_q == STARVE_MAX));

  always_comb begin
    state_d      = state_q;
    gnt_d_d      = gnt_d_q;
    m_ce_d       = m_ce_q;
    m_wrn_d      = m_wrn_q;
    m_addr_d     = m_addr_q;
    m_wrdata_d   = m_wrdata_q;
    d_rdata_d    = d_rdata_q;
    i_rdata_d    = i_rdata_q;
    d_done_d     = 1'b0;
    i_done_d     = 1'b0;
    err_d        = 1'b0;
    starve_cnt_d = starve_cnt_q;
    to_cnt_d     = to_cnt_q;

    case (state_q)
      IDLE: begin
        if (!bus.i_ce) begin
          starve_cnt_d = '0;
        end
        if (req_any) begin
          state_d  = BUSY;
          m_ce_d   = 1'b1;
          to_cnt_d = '0;
          gnt_d_d  = pick_d;
          if (pick_d) begin
            m_wrn_d    = bus.d_wrn;
            m_addr_d   = bus.d_addr;
            m_wrdata_d = bus.d_wrdata;
            if (bus.i_ce && (starve_cnt_q != STARVE_MAX)) begin
              starve_cnt_d = starve_cnt_q + SW'(1);
            end
          end else begin
            // fetch is always a read
            m_wrn_d      = 1'b0;
            m_addr_d     = bus.i_addr;
            m_wrdata_d   = '0;
            starve_cnt_d = '0;
          end
        end
      end

      BUSY: begin
        if (bus.m_ready) begin
          state_d = IDLE;
          m_ce_d  = 1'b0;
          m_wrn_d = 1'b0;
          if (gnt_d_q) begin
            d_done_d = 1'b1;
            if (!m_wrn_q) begin
              d_rdata_d = bus.m_rdata;
            end
          end else begin
            i_done_d  = 1'b1;
            i_rdata_d = bus.m_rdata;
          end
        end else if (to_cnt_q == TO_LAST) begin
          // abort: grantee still gets done so it is not left stalled
          state_d = IDLE;
          m_ce_d  = 1'b0;
          m_wrn_d = 1'b0;
          err_d   = 1'b1;
          if (gnt_d_q) begin
            d_done_d = 1'b1;
            if (!m_wrn_q) begin
              d_rdata_d = '0;
            end
          end else begin
            i_done_d  = 1'b1;
            i_rdata_d = '0;
          end
        end else begin
          to_cnt_d = to_cnt_q + 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
        m_ce_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_d_q      <= 1'b0;
      m_ce_q       <= 1'b0;
      m_wrn_q      <= 1'b0;
      m_addr_q     <= '0;
      m_wrdata_q   <= '0;
      d_rdata_q    <= '0;
      i_rdata_q    <= '0;
      d_done_q     <= 1'b0;
      i_done_q     <= 1'b0;
      err_q        <= 1'b0;
      starve_cnt_q <= '0;
      to_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      gnt_d_q      <= gnt_d_d;
      m_ce_q       <= m_ce_d;
      m_wrn_q      <= m_wrn_d;
      m_addr_q     <= m_addr_d;
      m_wrdata_q   <= m_wrdata_d;
      d_rdata_q    <= d_rdata_d;
      i_rdata_q    <= i_rdata_d;
      d_done_q     <= d_done_d;
      i_done_q     <= i_done_d;
      err_q        <= err_d;
      starve_cnt_q <= starve_cnt_d;
      to_cnt_q     <= to_cnt_d;
    end
  end

  assign bus.m_ce     = m_ce_q;
  assign bus.m_wrn    = m_wrn_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_wrdata = m_wrdata_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.i_rdata  = i_rdata_q;
  assign bus.d_done   = d_done_q;
  assign bus.i_done   = i_done_q;
  assign bus.err_o    = err_q;

  // stall drops in the done cycle so the pipeline advances exactly then
  assign bus.stall_o = (bus.d_ce & ~d_done_q) | (bus.i_ce & ~i_done_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .STARVE_LIMIT(4),
    .TIMEOUT     (15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // inputs are changed and outputs sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_addr;
    logic        exp_is_d;
    n_checks = 0;
    n_fail   = 0;
    rst          = 1'b1;
    bus.d_ce     = 1'b0;
    bus.d_wrn    = 1'b0;
    bus.d_addr   = '0;
    bus.d_wrdata = '0;
    bus.i_ce     = 1'b0;
    bus.i_addr   = '0;
    bus.m_rdata  = '0;
    bus.m_ready  = 1'b0;

    // ---- reset state
    tick();
    tick();
    chk1 ("rst_m_ce", bus.m_ce, 1'b0);
    chk1 ("rst_m_wrn", bus.m_wrn, 1'b0);
    chk32("rst_m_addr", bus.m_addr, 32'h0);
    chk32("rst_d_rdata", bus.d_rdata, 32'h0);
    chk32("rst_i_rdata", bus.i_rdata, 32'h0);
    chk1 ("rst_d_done", bus.d_done, 1'b0);
    chk1 ("rst_i_done", bus.i_done, 1'b0);
    chk1 ("rst_err", bus.err_o, 1'b0);
    chk1 ("rst_stall", bus.stall_o, 1'b0);
    rst = 1'b0;
    tick();

    // ---- D write, m_ready in 2nd busy cycle
    bus.d_ce = 1'b1; bus.d_wrn = 1'b1; bus.d_addr = 32'h10; bus.d_wrdata = 32'hDEADBEEF;
    #1 chk1("wr_c0_stall", bus.stall_o, 1'b1);
    tick(); // cycle 1
    chk1 ("wr_c1_m_ce", bus.m_ce, 1'b1);
    chk1 ("wr_c1_m_wrn", bus.m_wrn, 1'b1);
    chk32("wr_c1_m_addr", bus.m_addr, 32'h10);
    chk32("wr_c1_m_wrdata", bus.m_wrdata, 32'hDEADBEEF);
    chk1 ("wr_c1_stall", bus.stall_o, 1'b1);
    tick(); // cycle 2
    chk1 ("wr_c2_m_ce", bus.m_ce, 1'b1);
    chk32("wr_c2_m_addr", bus.m_addr, 32'h10);
    chk1 ("wr_c2_d_done", bus.d_done, 1'b0);
    chk1 ("wr_c2_stall", bus.stall_o, 1'b1);
    bus.m_ready = 1'b1;
    tick(); // cycle 3
    bus.m_ready = 1'b0;
    chk1 ("wr_c3_d_done", bus.d_done, 1'b1);
    chk1 ("wr_c3_m_ce", bus.m_ce, 1'b0);
    chk1 ("wr_c3_stall", bus.stall_o, 1'b0);
    chk32("wr_c3_d_rdata", bus.d_rdata, 32'h0);
    bus.d_ce = 1'b0;
    tick();
    chk1 ("wr_c4_d_done", bus.d_done, 1'b0);
    chk1 ("wr_c4_m_ce", bus.m_ce, 1'b0);

    // ---- D read, m_ready in first busy cycle
    bus.d_ce = 1'b1; bus.d_wrn = 1'b0; bus.d_addr = 32'h10;
    tick(); // cycle 1
    chk1 ("rd_c1_m_ce", bus.m_ce, 1'b1);
    chk1 ("rd_c1_m_wrn", bus.m_wrn, 1'b0);
    bus.m_ready = 1'b1; bus.m_rdata = 32'hDEADBEEF;
    tick(); // cycle 2
    bus.m_ready = 1'b0; bus.m_rdata = 32'h0;
    chk1 ("rd_c2_d_done", bus.d_done, 1'b1);
    chk32("rd_c2_d_rdata", bus.d_rdata, 32'hDEADBEEF);
    bus.d_ce = 1'b0;
    tick();
    chk1 ("rd_c3_d_done", bus.d_done, 1'b0);
    chk32("rd_c3_d_rdata_held", bus.d_rdata, 32'hDEADBEEF);

    // ---- contention: expected grant order D,D,D,D,I,D
    bus.d_ce = 1'b1; bus.d_wrn = 1'b0; bus.d_addr = 32'h100;
    bus.i_ce = 1'b1; bus.i_addr = 32'h200;
    bus.m_ready = 1'b1;
    for (int g = 0; g < 6; g++) begin
      exp_is_d = (g != 4);
      exp_addr = exp_is_d ? 32'h100 : 32'h200;
      bus.m_rdata = 32'hA000_0000 + 32'(g);
      tick(); // busy
      chk1 ($sformatf("ct%0d_m_ce", g), bus.m_ce, 1'b1);
      chk32($sformatf("ct%0d_m_addr", g), bus.m_addr, exp_addr);
      tick(); // done / next grant
      chk1 ($sformatf("ct%0d_d_done", g), bus.d_done, exp_is_d);
      chk1 ($sformatf("ct%0d_i_done", g), bus.i_done, !exp_is_d);
      if (!exp_is_d) chk32("ct_i_rdata", bus.i_rdata, 32'hA000_0004);
      if (g == 5) begin
        chk32("ct_d_rdata", bus.d_rdata, 32'hA000_0005);
        bus.d_ce = 1'b0; bus.i_ce = 1'b0; bus.m_ready = 1'b0; bus.m_rdata = 32'h0;
      end
    end
    tick();
    chk1("ct_end_m_ce", bus.m_ce, 1'b0);

    // ---- timeout on I: 15 busy cycles then abort
    bus.i_ce = 1'b1; bus.i_addr = 32'h40;
    for (int c = 0; c < 15; c++) begin
      tick();
      chk1($sformatf("to_busy%0d_m_ce", c), bus.m_ce, 1'b1);
      chk1($sformatf("to_busy%0d_err", c), bus.err_o, 1'b0);
    end
    chk32("to_m_addr", bus.m_addr, 32'h40);
    tick();
    chk1 ("to_err", bus.err_o, 1'b1);
    chk1 ("to_i_done", bus.i_done, 1'b1);
    chk32("to_i_rdata", bus.i_rdata, 32'h0);
    chk1 ("to_m_ce", bus.m_ce, 1'b0);
    bus.i_addr = 32'h44; // next fetch, sampled in this idle cycle
    tick();
    chk1 ("to_next_m_ce", bus.m_ce, 1'b1);
    chk32("to_next_m_addr", bus.m_addr, 32'h44);
    chk1 ("to_next_err", bus.err_o, 1'b0);
    bus.m_ready = 1'b1; bus.m_rdata = 32'h12345678;
    tick();
    bus.m_ready = 1'b0; bus.m_rdata = 32'h0; bus.i_ce = 1'b0;
    chk1 ("to_next_i_done", bus.i_done, 1'b1);
    chk32("to_next_i_rdata", bus.i_rdata, 32'h12345678);
    chk1 ("to_next_err2", bus.err_o, 1'b0);
    tick();

    // ---- reset mid-busy, then fresh access with d_ce still high
    bus.d_ce = 1'b1; bus.d_wrn = 1'b0; bus.d_addr = 32'h20;
    tick();
    chk1("rb_busy_m_ce", bus.m_ce, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1 ("rb_m_ce", bus.m_ce, 1'b0);
    chk1 ("rb_d_done", bus.d_done, 1'b0);
    chk1 ("rb_err", bus.err_o, 1'b0);
    chk32("rb_d_rdata", bus.d_rdata, 32'h0);
    tick();
    chk1 ("rb_fresh_m_ce", bus.m_ce, 1'b1);
    chk32("rb_fresh_m_addr", bus.m_addr, 32'h20);
    chk1 ("rb_fresh_d_done", bus.d_done, 1'b0);
    bus.m_ready = 1'b1; bus.m_rdata = 32'h0000_55AA;
    tick();
    bus.m_ready = 1'b0; bus.d_ce = 1'b0;
    chk1 ("rb_fresh_done", bus.d_done, 1'b1);
    chk32("rb_fresh_rdata", bus.d_rdata, 32'h0000_55AA);
    tick();

    // ---- m_ready while idle is ignored
    bus.m_ready = 1'b1; bus.m_rdata = 32'hFFFF_FFFF;
    tick();
    tick();
    chk1 ("ig_d_done", bus.d_done, 1'b0);
    chk1 ("ig_i_done", bus.i_done, 1'b0);
    chk1 ("ig_m_ce", bus.m_ce, 1'b0);
    chk32("ig_d_rdata", bus.d_rdata, 32'h0000_55AA);
    chk32("ig_i_rdata", bus.i_rdata, 32'h0);
    bus.m_ready = 1'b0; bus.m_rdata = 32'h0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
